// File: rtl/mipsfpga_ahb_uart_tx_pkg.sv
// Shared register map, STATUS bit positions and FSM encoding for the AHB UART transmitter.
package mipsfpga_ahb_uart_tx_pkg;

    // Index of the HSEL line the fabric decoder drives for this slave
    localparam int H_UART_ADDR_Match = 3;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // A programmed divisor of 0 is treated as a one-cycle bit
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/mipsfpga_ahb_uart_tx_if.sv
// Data-phase-aligned AHB-lite slave signals (address, write strobe and select already delayed).
interface mipsfpga_ahb_uart_tx_if;
    logic [1:0]  HADDR_d;
    logic [31:0] HWDATA;
    logic        HWRITE_d;
    logic        HSEL;
    logic [31:0] HRDATA;

    modport master (output HADDR_d, output HWDATA, output HWRITE_d, output HSEL, input HRDATA);
    modport slave  (input HADDR_d, input HWDATA, input HWRITE_d, input HSEL, output HRDATA);
endinterface

// File: rtl/mipsfpga_ahb_uart_tx_fifo.sv
// Synchronous byte FIFO; push visible in count next cycle, dout is the head (combinational).
// Backpressure: push while full and pop while empty are ignored; caller checks full/empty.
module mipsfpga_ahb_uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/mipsfpga_ahb_uart_tx.sv
// AHB-lite UART transmitter: TX FIFO feeding an 8N1 serialiser; start bit one cycle after a byte lands.
// Backpressure: none on the bus; TXDATA writes while full are dropped and flagged in STATUS.ovf.
module mipsfpga_ahb_uart_tx
    import mipsfpga_ahb_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    mipsfpga_ahb_uart_tx_if.slave bus,
    output logic                  UART_TX,
    output logic                  TX_IRQ
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr, push, full, empty, pop, load_cnt, shift, tx_nxt, tick, ovf;
    logic [CW-1:0] count, count_nxt;
    logic [7:0]    fifo_dout, shreg;
    logic [15:0]   baud_div, baud_cnt;
    logic [2:0]    bit_idx;
    logic [31:0]   status;
    tx_state_t     state, state_nxt;
    logic          unused_hwdata;

    assign wr            = bus.HSEL & bus.HWRITE_d;
    assign push          = wr && (bus.HADDR_d == UART_TXDATA);
    assign tick          = (baud_cnt == 16'd0);
    assign count_nxt     = count + CW'(push & ~full) - CW'(pop);
    assign unused_hwdata = ^bus.HWDATA[31:16];

    mipsfpga_ahb_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push),
        .din   (bus.HWDATA[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Full is judged at the start of the cycle, so a same-cycle pop never rescues a push
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            baud_div <= DIV_RESET;
            ovf      <= 1'b0;
        end else begin
            if (wr && bus.HADDR_d == UART_BAUDDIV) baud_div <= bus.HWDATA[15:0];
            if (push && full) begin
                ovf <= 1'b1;
            end else if (wr && bus.HADDR_d == UART_STATUS && bus.HWDATA[ST_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        status                    = '0;
        status[ST_FULL]           = full;
        status[ST_EMPTY]          = empty;
        status[ST_BUSY]           = (state != S_IDLE);
        status[ST_OVF]            = ovf;
        status[ST_CNT_LSB +: 8]   = 8'(count);
    end

    always_comb begin
        bus.HRDATA = '0;
        if (bus.HSEL) begin
            case (bus.HADDR_d)
                UART_STATUS:  bus.HRDATA = status;
                UART_BAUDDIV: bus.HRDATA = {16'd0, baud_div};
                default:      bus.HRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty)                     state_nxt = S_START;
            S_START: if (tick)                       state_nxt = S_DATA;
            S_DATA:  if (tick && bit_idx == 3'd7)    state_nxt = S_STOP;
            S_STOP:  if (tick)                       state_nxt = empty ? S_IDLE : S_START;
            default:                                 state_nxt = S_IDLE;
        endcase
    end

    // shreg is pre-shifted, so shreg[0] always holds the next data bit to drive
    always_comb begin
        pop      = 1'b0;
        load_cnt = 1'b0;
        shift    = 1'b0;
        tx_nxt   = UART_TX;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    load_cnt = 1'b1;
                    tx_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    load_cnt = 1'b1;
                    shift    = 1'b1;
                    tx_nxt   = shreg[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    load_cnt = 1'b1;
                    if (bit_idx == 3'd7) begin
                        tx_nxt = 1'b1;
                    end else begin
                        shift  = 1'b1;
                        tx_nxt = shreg[0];
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    load_cnt = 1'b1;
                    if (!empty) begin
                        pop    = 1'b1;
                        tx_nxt = 1'b0;
                    end
                end
            end
            default: tx_nxt = 1'b1;
        endcase
    end

    // Divisor is sampled only at reload, so a mid-bit BAUDDIV write leaves the current bit intact
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            UART_TX  <= 1'b1;
            TX_IRQ   <= 1'b1;
            shreg    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
        end else begin
            UART_TX <= tx_nxt;
            TX_IRQ  <= (state_nxt == S_IDLE) && (count_nxt == '0);
            if (pop)        shreg <= fifo_dout;
            else if (shift) shreg <= {1'b0, shreg[7:1]};
            if (state == S_START && tick)     bit_idx <= 3'd0;
            else if (state == S_DATA && tick) bit_idx <= bit_idx + 3'd1;
            if (load_cnt)                baud_cnt <= bit_period(baud_div) - 16'd1;
            else if (baud_cnt != 16'd0)  baud_cnt <= baud_cnt - 16'd1;
        end
    end
endmodule

// File: tb/tb_mipsfpga_ahb_uart_tx.sv
// Directed + randomized bench for mipsfpga_ahb_uart_tx against a bit-level 8N1 waveform model.
module tb_mipsfpga_ahb_uart_tx;
    localparam int DEPTH = 8;
    localparam int LOGN  = 4096;

    logic HCLK = 1'b0;
    logic HRESET;
    logic UART_TX, TX_IRQ;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic tx_log [LOGN];

    mipsfpga_ahb_uart_tx_if bus_if();

    mipsfpga_ahb_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .bus     (bus_if),
        .UART_TX (UART_TX),
        .TX_IRQ  (TX_IRQ)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;
    always @(negedge HCLK) if (cyc < LOGN) tx_log[cyc] = UART_TX;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] st(input logic full, input logic empty, input logic busy,
                                       input logic ovf, input int cnt);
        logic [7:0] c;
        c = cnt[7:0];
        return {16'h0, c, 4'h0, ovf, busy, empty, full};
    endfunction

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    // Expected line waveform: start bit (d0 cycles), 8 data bits LSB first and stop bit (d1 cycles each)
    function automatic void frame_wave(input logic [7:0] b, input int d0, input int d1,
                                       output logic [63:0] w, output int len);
        w   = '1;
        len = 0;
        for (int k = 0; k < 10; k++) begin
            logic v;
            v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            for (int j = 0; j < ((k == 0) ? d0 : d1); j++) begin
                w[len] = v;
                len++;
            end
        end
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge HCLK);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input int d0, input int d1,
                               input int s, output int len);
        logic [63:0] exp_w, obs_w;
        frame_wave(b, d0, d1, exp_w, len);
        wait_cyc(s + len);
        obs_w = '1;
        for (int i = 0; i < len; i++) obs_w[i] = tx_log[s + i];
        chk(tag, obs_w, exp_w);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.HSEL     = 1'b1;
        bus_if.HWRITE_d = 1'b1;
        bus_if.HADDR_d  = a;
        bus_if.HWDATA   = d;
        @(posedge HCLK);
        @(negedge HCLK);
        bus_if.HSEL     = 1'b0;
        bus_if.HWRITE_d = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus_if.HSEL     = 1'b1;
        bus_if.HWRITE_d = 1'b0;
        bus_if.HADDR_d  = a;
        #1;
        d = bus_if.HRDATA;
        bus_if.HSEL = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  bytes [10];
        logic [7:0]  b1, b2;
        logic [63:0] w;
        int          s, len, d;

        bus_if.HSEL = 1'b0; bus_if.HWRITE_d = 1'b0; bus_if.HADDR_d = 2'd0; bus_if.HWDATA = '0;
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;

        // Reset state
        rd(2'd1, r); chk("rst_status", r, st(0, 1, 0, 0, 0));
        rd(2'd2, r); chk("rst_bauddiv", r, 434);
        chk("rst_uart_tx", UART_TX, 1);
        chk("rst_irq", TX_IRQ, 1);

        // Single 0x55 frame at 4 cycles/bit
        wr(2'd2, 32'd4);
        rd(2'd2, r); chk("bauddiv_rd", r, 4);
        wr(2'd0, 32'h55);
        s = cyc + 1;
        chk("irq_low_when_queued", TX_IRQ, 0);
        check_frame("frame_55", 8'h55, 4, 4, s, len);
        chk("irq_after_55", TX_IRQ, 1);
        chk("idle_after_55", UART_TX, 1);
        rd(2'd1, r); chk("status_after_55", r, st(0, 1, 0, 0, 0));

        // Ten back-to-back writes at 2 cycles/bit: one popped, DEPTH queued, last one dropped
        wr(2'd2, 32'd2);
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 10; i++) begin
            bus_if.HSEL = 1'b1; bus_if.HWRITE_d = 1'b1;
            bus_if.HADDR_d = 2'd0; bus_if.HWDATA = {24'h0, bytes[i]};
            @(posedge HCLK);
            @(negedge HCLK);
            if (i == 0) s = cyc + 1;
        end
        bus_if.HSEL = 1'b0; bus_if.HWRITE_d = 1'b0;
        rd(2'd1, r); chk("b2b_full_ovf", r, st(1, 0, 1, 1, DEPTH));
        wr(2'd1, 32'h7);
        rd(2'd1, r); chk("w1c_other_bits", r, st(1, 0, 1, 1, DEPTH));
        wr(2'd1, 32'h8);
        rd(2'd1, r); chk("w1c_ovf", r, st(1, 0, 1, 0, DEPTH));
        for (int f = 0; f < DEPTH + 1; f++)
            check_frame($sformatf("b2b_frame%0d", f), bytes[f], 2, 2, s + f * 20, len);
        chk("b2b_idle_line", UART_TX, 1);
        chk("b2b_irq", TX_IRQ, 1);

        // Divisor 0 behaves as 1
        wr(2'd2, 32'd0);
        rd(2'd2, r); chk("bauddiv_zero_rd", r, 0);
        wr(2'd0, 32'hA5);
        s = cyc + 1;
        check_frame("frame_a5_div0", 8'hA5, 1, 1, s, len);
        chk("irq_after_a5", TX_IRQ, 1);

        // BAUDDIV change during the start bit applies from the next bit
        wr(2'd2, 32'd3);
        b1 = 8'($urandom_range(0, 255));
        wr(2'd0, {24'h0, b1});
        s = cyc + 1;
        @(negedge HCLK);
        wr(2'd2, 32'd5);
        check_frame("frame_midbit_div", b1, 3, 5, s, len);

        // Randomized single frames
        for (int i = 0; i < 4; i++) begin
            d  = $urandom_range(0, 6);
            b1 = 8'($urandom_range(0, 255));
            wr(2'd2, d);
            wr(2'd0, {24'h0, b1});
            s = cyc + 1;
            check_frame($sformatf("rand_frame%0d", i), b1, eff(d), eff(d), s, len);
            chk($sformatf("rand_irq%0d", i), TX_IRQ, 1);
        end

        // Reset during data bit 3
        wr(2'd2, 32'd4);
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        wr(2'd0, {24'h0, b1});
        s = cyc + 1;
        wr(2'd0, {24'h0, b2});
        wait_cyc(s + 17);
        chk("data_bit3", UART_TX, b1[3]);
        rd(2'd1, r); chk("status_mid_frame", r, st(0, 0, 1, 0, 1));
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        chk("rst_mid_uart_tx", UART_TX, 1);
        chk("rst_mid_irq", TX_IRQ, 1);
        rd(2'd1, r); chk("rst_mid_status", r, st(0, 1, 0, 0, 0));
        rd(2'd2, r); chk("rst_mid_bauddiv", r, 434);
        s = cyc + 1;
        wait_cyc(s + 8);
        w = '1;
        for (int i = 0; i < 8; i++) w[i] = tx_log[s + i];
        chk("rst_mid_line_idle", w, 64'hFFFF_FFFF_FFFF_FFFF);

        // Unselected and reserved-offset accesses
        bus_if.HSEL = 1'b0; bus_if.HWRITE_d = 1'b0; bus_if.HADDR_d = 2'd1;
        #1 chk("rd_hsel0", bus_if.HRDATA, 0);
        bus_if.HWRITE_d = 1'b1; bus_if.HADDR_d = 2'd0; bus_if.HWDATA = 32'h3C;
        @(posedge HCLK);
        @(negedge HCLK);
        bus_if.HWRITE_d = 1'b0;
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd1, r); chk("no_push_status", r, st(0, 1, 0, 0, 0));
        rd(2'd3, r); chk("rd_reserved", r, 0);
        rd(2'd0, r); chk("rd_txdata", r, 0);
        rd(2'd2, r); chk("reserved_wr_bauddiv", r, 434);
        repeat (3) @(negedge HCLK);
        chk("no_push_line", UART_TX, 1);
        chk("no_push_irq", TX_IRQ, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
